// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: datapath width, register index width and
// writeback source select encodings.
package cpu_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned REG_ADDR_W = 4;

    localparam logic WB_SEL_DM  = 1'b1;
    localparam logic WB_SEL_ALU = 1'b0;

endpackage

// File: rtl/writeback_mux.sv
// Writeback source select: memory load data or ALU result.
module writeback_mux
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] wb_dm,
    input  logic [WIDTH-1:0] wb_ALU,
    input  logic             wb_muxWB,
    output logic [WIDTH-1:0] wb_data
);

    always_comb begin
        wb_data = wb_ALU;
        if (wb_muxWB == WB_SEL_DM) begin
            wb_data = wb_dm;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Architectural register file fed by the WB stage, with write-through read
// bypass and a WB forwarding bus.
module writeback_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH,
    parameter int unsigned NREG  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      wb_dm,
    input  logic [WIDTH-1:0]      wb_ALU,
    input  logic [WIDTH-1:0]      wb_R0,
    input  logic [REG_ADDR_W-1:0] wb_wAddr,
    input  logic                  wb_muxWB,
    input  logic                  wb_regWrite,
    input  logic                  wb_regWrite0,
    input  logic [REG_ADDR_W-1:0] RR1,
    input  logic [REG_ADDR_W-1:0] RR2,
    output logic [WIDTH-1:0]      RD1,
    output logic [WIDTH-1:0]      RD2,
    output logic [WIDTH-1:0]      R0_out,
    output logic [WIDTH-1:0]      fwd_data,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_valid
);

    logic [WIDTH-1:0] wb_data;
    logic [WIDTH-1:0] regs_q [NREG];

    writeback_mux #(
        .WIDTH (WIDTH)
    ) u_writeback_mux (
        .wb_dm    (wb_dm),
        .wb_ALU   (wb_ALU),
        .wb_muxWB (wb_muxWB),
        .wb_data  (wb_data)
    );

    // The R0 write is issued last so it overrides a primary write aimed at R0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wb_regWrite) begin
                regs_q[wb_wAddr] <= wb_data;
            end
            if (wb_regWrite0) begin
                regs_q[0] <= wb_R0;
            end
        end
    end

    function automatic logic [WIDTH-1:0] bypass_read(input logic [REG_ADDR_W-1:0] addr,
                                                     input logic [WIDTH-1:0]      stored);
        logic [WIDTH-1:0] val;
        val = stored;
        if (addr == '0 && wb_regWrite0) begin
            val = wb_R0;
        end else if (wb_regWrite && wb_wAddr == addr) begin
            val = wb_data;
        end
        return val;
    endfunction

    always_comb begin
        RD1    = bypass_read(RR1, regs_q[RR1]);
        RD2    = bypass_read(RR2, regs_q[RR2]);
        R0_out = bypass_read('0, regs_q[0]);
    end

    always_comb begin
        fwd_valid = wb_regWrite;
        fwd_addr  = wb_wAddr;
        fwd_data  = wb_data;
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: directed cases plus random traffic
// checked against an array model of the register file.
module tb_writeback_regfile;

    localparam int W = 16;
    localparam int N = 16;

    typedef struct {
        int         id;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] r0;
        logic         fv;
        logic [3:0]   fa;
        logic [W-1:0] fd;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] wb_dm = '0, wb_ALU = '0, wb_R0 = '0;
    logic [3:0]   wb_wAddr = '0, RR1 = '0, RR2 = '0;
    logic         wb_muxWB = 1'b0, wb_regWrite = 1'b0, wb_regWrite0 = 1'b0;
    logic [W-1:0] RD1, RD2, R0_out, fwd_data;
    logic [3:0]   fwd_addr;
    logic         fwd_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int step_id  = 0;

    exp_t         sb_q[$];
    logic [W-1:0] model   [N];
    logic [W-1:0] pending [N];

    writeback_regfile #(
        .WIDTH (W),
        .NREG  (N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_dm        (wb_dm),
        .wb_ALU       (wb_ALU),
        .wb_R0        (wb_R0),
        .wb_wAddr     (wb_wAddr),
        .wb_muxWB     (wb_muxWB),
        .wb_regWrite  (wb_regWrite),
        .wb_regWrite0 (wb_regWrite0),
        .RR1          (RR1),
        .RR2          (RR2),
        .RD1          (RD1),
        .RD2          (RD2),
        .R0_out       (R0_out),
        .fwd_data     (fwd_data),
        .fwd_addr     (fwd_addr),
        .fwd_valid    (fwd_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, id, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each pending expectation is
    // compared on the falling edge following its stimulus.
    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("RD1", e.id, 32'(RD1), 32'(e.rd1));
            chk("RD2", e.id, 32'(RD2), 32'(e.rd2));
            chk("R0_out", e.id, 32'(R0_out), 32'(e.r0));
            chk("fwd_valid", e.id, 32'(fwd_valid), 32'(e.fv));
            chk("fwd_addr", e.id, 32'(fwd_addr), 32'(e.fa));
            chk("fwd_data", e.id, 32'(fwd_data), 32'(e.fd));
        end
    end

    // One cycle: commit last cycle's writes to the model at the edge (unless
    // held in reset), then drive new inputs and predict the outputs. A read
    // during a pending write shows the value the register will hold next.
    task automatic step(input logic [W-1:0] dm, input logic [W-1:0] alu,
                        input logic [W-1:0] r0v, input logic [3:0] waddr,
                        input logic sel, input logic we, input logic we0,
                        input logic [3:0] rr1v, input logic [3:0] rr2v,
                        input logic rst);
        exp_t         e;
        logic [W-1:0] data;
        @(posedge clock);
        if (!reset) model = pending;
        #1;
        wb_dm = dm; wb_ALU = alu; wb_R0 = r0v; wb_wAddr = waddr; wb_muxWB = sel;
        wb_regWrite = we; wb_regWrite0 = we0; RR1 = rr1v; RR2 = rr2v; reset = rst;
        if (rst) begin
            for (int i = 0; i < N; i++) model[i] = '0;
        end
        data    = sel ? dm : alu;
        pending = model;
        if (we)  pending[waddr] = data;
        if (we0) pending[0]     = r0v;
        step_id++;
        e.id  = step_id;
        e.rd1 = pending[rr1v];
        e.rd2 = pending[rr2v];
        e.r0  = pending[0];
        e.fv  = we;
        e.fa  = waddr;
        e.fd  = data;
        sb_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            model[i]   = '0;
            pending[i] = '0;
        end
        // Reset, then read R5 / R0.
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 1'b1);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 1'b0);
        // ALU write to R3: bypass, then stored.
        step('0, 16'h1234, '0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0);
        // Load-data write to R7 with forwarding bus, then read via RR2.
        step(16'hBEEF, 16'h0BAD, '0, 4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b0);
        // Both enables at R0: R0 write wins.
        step('0, 16'h1111, 16'h2222, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0);
        // Both enables, distinct targets.
        step('0, 16'hAAAA, 16'h5555, 4'd4, 1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 1'b0);
        // Write R9, read it, then assert reset between edges.
        step('0, 16'h00FF, '0, 4'd9, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 1'b0);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd4, 1'b0);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd4, 1'b1);
        // Writes held off while in reset, but bypass still visible.
        step(16'h7777, '0, 16'h3333, 4'd2, 1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 1'b1);
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0);
        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            step(16'($urandom()), 16'($urandom()), 16'($urandom()),
                 4'($urandom()), 1'($urandom()),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 4'($urandom()), 4'($urandom()),
                 ($urandom_range(0, 39) == 0));
        end
        step('0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", 0, 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter NREG, default 16, number of architectural registers (R0..R15).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wb_dm  input  WIDTH  memory load data from MEM/WB stage.
REQ-006 wb_ALU  input  WIDTH  ALU result from MEM/WB stage.
REQ-007 wb_R0  input  WIDTH  secondary result destined for R0 (mult/div high word).
REQ-008 wb_wAddr  input  4  destination register index.
REQ-009 wb_muxWB  input  1  writeback source select: 1 = wb_dm, 0 = wb_ALU.
REQ-010 wb_regWrite  input  1  write enable for the primary result into wb_wAddr.
REQ-011 wb_regWrite0  input  1  write enable for wb_R0 into R0.
REQ-012 RR1, RR2  input  4 each  decode-stage read addresses.
REQ-013 RD1, RD2  output  WIDTH each  read data for RR1/RR2.
REQ-014 R0_out  output  WIDTH  current (bypassed) value of R0.
REQ-015 fwd_data, fwd_addr, fwd_valid  output  WIDTH/4/1  WB-stage forwarding bus to the forwarding unit.

Function
REQ-016 wb_data SHALL be wb_dm when wb_muxWB=1, else wb_ALU; purely combinational.
REQ-017 On a rising clock edge with wb_regWrite=1, register[wb_wAddr] SHALL take wb_data.
REQ-018 On a rising clock edge with wb_regWrite0=1, register[0] SHALL take wb_R0.
REQ-019 If both enables are set and wb_wAddr=0, register[0] SHALL take wb_R0 (regWrite0 wins); wb_data is discarded.
REQ-020 If both enables are set and wb_wAddr!=0, both writes SHALL occur in the same cycle.
REQ-021 With both enables low, no register SHALL change, regardless of other inputs.
REQ-022 RD1/RD2 SHALL be combinational reads with write-through bypass: same-cycle pending write to the addressed register is returned instead of stored value.
REQ-023 Bypass priority for address 0: wb_R0 if wb_regWrite0, else wb_data if wb_regWrite and wb_wAddr=0, else stored value.
REQ-024 Bypass for address n!=0: wb_data if wb_regWrite and wb_wAddr=n, else stored value.
REQ-025 R0_out SHALL equal the address-0 read result per REQ-023.
REQ-026 fwd_valid SHALL equal wb_regWrite; fwd_addr SHALL equal wb_wAddr; fwd_data SHALL equal wb_data; all combinational, zero latency.
REQ-027 Write latency: value written at edge k SHALL be visible on stored-read path from edge k onward and on bypass path during cycle k-1.

Reset
REQ-028 Asserting reset SHALL immediately clear all NREG registers to 0, independent of clock.
REQ-029 While reset is high, writes SHALL be suppressed; RD1/RD2/R0_out SHALL still reflect bypass logic on current inputs.
REQ-030 A write whose edge coincides with reset assertion SHALL be lost; registers read 0 after release.

Structure
REQ-031 WIDTH, register address width (4), and WB_SEL_DM/WB_SEL_ALU encodings SHALL live in the shared cpu_pkg package.
REQ-032 The source mux (REQ-016) SHALL be a sub-module named writeback_mux; storage and bypass stay in writeback_regfile.

Verification
REQ-033 Reset, then RR1=5,RR2=0 -> RD1=0x0000, RD2=0x0000, R0_out=0x0000.
REQ-034 wb_muxWB=0, wb_ALU=0x1234, wb_wAddr=3, wb_regWrite=1, RR1=3 -> RD1=0x1234 same cycle (bypass), still 0x1234 next cycle with enables low.
REQ-035 wb_muxWB=1, wb_dm=0xBEEF, wb_wAddr=7, wb_regWrite=1 -> fwd_valid=1, fwd_addr=7, fwd_data=0xBEEF; next cycle RR2=7 -> RD2=0xBEEF.
REQ-036 wb_wAddr=0, wb_ALU=0x1111, wb_R0=0x2222, both enables=1 -> R0_out=0x2222 same cycle and after edge.
REQ-037 wb_wAddr=4, wb_ALU=0xAAAA, wb_R0=0x5555, both enables=1 -> after edge reg4=0xAAAA, R0=0x5555.
REQ-038 Write reg9=0x00FF, then assert reset mid-cycle -> RD1 (RR1=9) drops to 0x0000 without a clock edge.
